// File: rtl/passcode_lock_pkg.sv
// State and answer encodings shared by the passcode lock.
// PROGRAM only exists when CODE_CHANGE_EN is defined.
package passcode_lock_pkg;

  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    CHECK   = 3'd1,
    SHOW    = 3'd2,
    LOCKOUT = 3'd3
`ifdef CODE_CHANGE_EN
    ,
    PROGRAM = 3'd4
`endif
  } lock_state_t;

  localparam logic [2:0] ANS_IDLE = 3'b000;
  localparam logic [2:0] ANS_PASS = 3'b001;
  localparam logic [2:0] ANS_FAIL = 3'b010;
  localparam logic [2:0] ANS_LOCK = 3'b100;

endpackage

// File: rtl/edge_detect_rise.sv
// One-cycle strobe on a 0->1 transition of a level input.
module edge_detect_rise (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Sig,
  output logic o_Rise
);

  logic sig_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) sig_q <= 1'b0;
    else       sig_q <= i_Sig;
  end

  assign o_Rise = i_Sig & ~sig_q;

endmodule

// File: rtl/passcode_lock_n.sv
// N-digit passcode lock with blink display and failure lockout.
// Define CODE_CHANGE_EN to add i_Change and the PROGRAM state for code changes.
module passcode_lock_n
  import passcode_lock_pkg::*;
#(
  parameter int                          DIGITS        = 4,
  parameter int                          DIGIT_W       = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE  = 'h1234,
  parameter int                          MAX_FAILS     = 3,
  parameter int                          COUNT_TICK    = 12500000,
  parameter int                          BLINK_TOGGLES = 7,
  parameter int                          LOCKOUT_TICKS = 16
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Enter,
  input  logic               i_Clear,
`ifdef CODE_CHANGE_EN
  input  logic               i_Change,
`endif
  input  logic [DIGIT_W-1:0] i_Digit,
  output logic [DIGITS-1:0]  o_Digit_LED,
  output logic [2:0]         o_Answer,
  output logic               o_Locked
);

  localparam int CODE_W   = DIGITS * DIGIT_W;
  localparam int IDX_W    = $clog2(DIGITS + 1);
  localparam int TICK_W   = $clog2(COUNT_TICK + 1);
  localparam int HALF_MAX = (BLINK_TOGGLES > LOCKOUT_TICKS) ? BLINK_TOGGLES : LOCKOUT_TICKS;
  localparam int HALF_W   = $clog2(HALF_MAX + 1);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(COUNT_TICK - 1);
  localparam logic [HALF_W-1:0] SHOW_LAST = HALF_W'(BLINK_TOGGLES - 1);
  localparam logic [HALF_W-1:0] LOCK_LAST = HALF_W'(LOCKOUT_TICKS - 1);
  localparam logic [3:0]        FAIL_MAX  = 4'(MAX_FAILS);

  lock_state_t       state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [3:0]        fails, fails_n, fails_inc;
  logic [TICK_W-1:0] tick, tick_n;
  logic [HALF_W-1:0] half, half_n;
  logic [CODE_W-1:0] entry_buf, entry_buf_n, buf_wr;
  logic [CODE_W-1:0] code_q;
  logic [DIGITS-1:0] led, led_n, led_set;
  logic [2:0]        ans, ans_n;
  logic              locked, locked_n;
  logic              commit_stb;
  logic              half_evt;

  edge_detect_rise u_enter_edge (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Sig  (i_Enter),
    .o_Rise (commit_stb)
  );

`ifdef CODE_CHANGE_EN
  logic [CODE_W-1:0] code_n;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) code_q <= DEFAULT_CODE;
    else       code_q <= code_n;
  end
`else
  assign code_q = DEFAULT_CODE;
`endif

  // Digit 0 lives in the most significant slot; its LED is bit 0.
  always_comb begin
    buf_wr  = entry_buf;
    led_set = led;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(idx) == i) begin
        buf_wr[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = i_Digit;
        led_set[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= ENTRY;
      idx       <= '0;
      fails     <= '0;
      tick      <= '0;
      half      <= '0;
      entry_buf <= '0;
      led       <= '0;
      ans       <= ANS_IDLE;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      fails     <= fails_n;
      tick      <= tick_n;
      half      <= half_n;
      entry_buf <= entry_buf_n;
      led       <= led_n;
      ans       <= ans_n;
      locked    <= locked_n;
    end
  end

  assign half_evt  = (tick == TICK_LAST);
  assign fails_inc = (fails == FAIL_MAX) ? fails : fails + 4'd1;

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    fails_n     = fails;
    tick_n      = '0;
    half_n      = '0;
    entry_buf_n = entry_buf;
    led_n       = led;
    ans_n       = ans;
    locked_n    = locked;
`ifdef CODE_CHANGE_EN
    code_n      = code_q;
`endif

    case (state)
      ENTRY: begin
        if (i_Clear) begin
          idx_n = '0;
          led_n = '0;
        end else if (commit_stb) begin
          entry_buf_n = buf_wr;
          led_n       = led_set;
          if (idx == IDX_LAST) begin
            idx_n   = '0;
            state_n = CHECK;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end

      CHECK: begin
        led_n = '1;
        if (entry_buf == code_q) begin
          ans_n   = ANS_PASS;
          fails_n = '0;
          state_n = SHOW;
        end else begin
          fails_n = fails_inc;
          if (fails_inc == FAIL_MAX) begin
            ans_n    = ANS_LOCK;
            locked_n = 1'b1;
            state_n  = LOCKOUT;
          end else begin
            ans_n   = ANS_FAIL;
            state_n = SHOW;
          end
        end
      end

      // The final half-period clears the LEDs instead of toggling them.
      SHOW: begin
        tick_n = half_evt ? '0 : tick + 1'b1;
        half_n = half;
        if (half_evt) begin
          if (half == SHOW_LAST) begin
            led_n   = '0;
            idx_n   = '0;
            state_n = ENTRY;
`ifdef CODE_CHANGE_EN
            if (i_Change && ans == ANS_PASS) state_n = PROGRAM;
`endif
          end else begin
            led_n  = ~led;
            half_n = half + 1'b1;
          end
        end
      end

      LOCKOUT: begin
        tick_n = half_evt ? '0 : tick + 1'b1;
        half_n = half;
        if (half_evt) begin
          if (half == LOCK_LAST) begin
            led_n    = '0;
            idx_n    = '0;
            fails_n  = '0;
            ans_n    = ANS_IDLE;
            locked_n = 1'b0;
            state_n  = ENTRY;
          end else begin
            led_n  = ~led;
            half_n = half + 1'b1;
          end
        end
      end

`ifdef CODE_CHANGE_EN
      PROGRAM: begin
        if (i_Clear) begin
          idx_n   = '0;
          led_n   = '0;
          state_n = ENTRY;
        end else if (commit_stb) begin
          entry_buf_n = buf_wr;
          led_n       = led_set;
          if (idx == IDX_LAST) begin
            code_n  = buf_wr;
            ans_n   = ANS_PASS;
            led_n   = '0;
            idx_n   = '0;
            state_n = ENTRY;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
`endif

      default: state_n = ENTRY;
    endcase

    if (state_n != state) begin
      tick_n = '0;
      half_n = '0;
    end
  end

  assign o_Digit_LED = led;
  assign o_Answer    = ans;
  assign o_Locked    = locked;

endmodule

// File: tb/tb_passcode_lock_n.sv
// Scoreboard bench for passcode_lock_n with a short blink period (COUNT_TICK=4).
// Defining CODE_CHANGE_EN also exercises reprogramming of the stored code.
module tb_passcode_lock_n;

  localparam int TICK     = 4;
  localparam int SHOW_LEN = TICK * 7;
  localparam int LOCK_LEN = TICK * 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] digit = 4'h0;
  logic [3:0] led;
  logic [2:0] answer;
  logic       locked;
`ifdef CODE_CHANGE_EN
  logic       change = 1'b0;
`endif

  passcode_lock_n #(
    .COUNT_TICK (TICK)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Enter     (enter),
    .i_Clear     (clear),
`ifdef CODE_CHANGE_EN
    .i_Change    (change),
`endif
    .i_Digit     (digit),
    .o_Digit_LED (led),
    .o_Answer    (answer),
    .o_Locked    (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic [3:0] led;
    logic [2:0] ans;
    logic       lock;
    string      name;
  } timed_t;

  typedef struct {
    logic [2:0] ans;
    logic       lock;
  } evt_t;

  timed_t timed_q[$];
  evt_t   evt_q[$];

  int vectors     = 0;
  int miscompares = 0;
  bit mon_en      = 1'b0;

  // Reference model of what the lock should be showing
  logic [3:0]  m_led  = 4'b0000;
  logic [2:0]  m_ans  = 3'b000;
  logic        m_lock = 1'b0;
  int          m_fails = 0;
  logic [15:0] m_code = 16'h1234;
  logic [2:0]  last_ans  = 3'b000;
  logic        last_lock = 1'b0;
  int          check_edge = 0;

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %b_%b_%b, want %b_%b_%b",
               name, cyc, got[7:4], got[3:1], got[0], want[7:4], want[3:1], want[0]);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic en, input logic clr, input logic r);
    @(negedge clk);
    digit = d;
    enter = en;
    clear = clr;
    rst   = r;
  endtask

  task automatic expect_at(input int stamp, input string name);
    timed_t t;
    t.stamp = stamp;
    t.led   = m_led;
    t.ans   = m_ans;
    t.lock  = m_lock;
    t.name  = name;
    timed_q.push_back(t);
  endtask

  task automatic note_answer();
    evt_t e;
    if (m_ans != last_ans || m_lock != last_lock) begin
      e.ans  = m_ans;
      e.lock = m_lock;
      evt_q.push_back(e);
      last_ans  = m_ans;
      last_lock = m_lock;
    end
  endtask

  // Four commits, then the expected CHECK outcome one edge after the last one.
  task automatic enter_code(input logic [15:0] code, input string name);
    int k;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(code[15-4*i -: 4], 1'b1, 1'b0, 1'b0);
      k = cyc + 1;
      m_led[i] = 1'b1;
      expect_at(k, $sformatf("%s_digit%0d", name, i));
      applyStimulus(code[15-4*i -: 4], 1'b0, 1'b0, 1'b0);
    end
    if (code == m_code) begin
      m_ans   = 3'b001;
      m_fails = 0;
    end else begin
      m_fails = (m_fails < 3) ? m_fails + 1 : 3;
      if (m_fails == 3) begin
        m_ans  = 3'b100;
        m_lock = 1'b1;
      end else begin
        m_ans = 3'b010;
      end
    end
    note_answer();
    check_edge = k + 1;
    expect_at(check_edge, {name, "_result"});
    @(negedge clk);
  endtask

  task automatic finish_show(input string name);
    int s = check_edge;
    m_led = 4'b0000;
    expect_at(s + TICK, {name, "_blink_off"});
    m_led = 4'b1111;
    expect_at(s + 2*TICK, {name, "_blink_on"});
    expect_at(s + SHOW_LEN - 1, {name, "_last_on"});
    m_led = 4'b0000;
    expect_at(s + SHOW_LEN, {name, "_show_done"});
    while (cyc < s + SHOW_LEN) @(negedge clk);
  endtask

  task automatic finish_lockout(input string name);
    int s = check_edge;
    m_led = 4'b0000;
    expect_at(s + TICK, {name, "_blink_off"});
    m_led = 4'b1111;
    expect_at(s + 2*TICK, {name, "_blink_on"});
    m_led = 4'b0000;
    expect_at(s + LOCK_LEN - 1, {name, "_still_locked"});
    m_ans   = 3'b000;
    m_lock  = 1'b0;
    m_fails = 0;
    expect_at(s + LOCK_LEN, {name, "_released"});
    note_answer();
    applyStimulus(4'h7, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'h7, 1'b0, 1'b0, 1'b0);
    while (cyc < s + LOCK_LEN) @(negedge clk);
  endtask

  initial begin : timed_monitor
    timed_t t;
    forever begin
      @(negedge clk);
      while (timed_q.size() > 0 && timed_q[0].stamp <= cyc) begin
        t = timed_q.pop_front();
        if (t.stamp < cyc) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL %s stale: checked at cycle %0d, required at %0d", t.name, cyc, t.stamp);
        end else begin
          checkOutput(t.name, {led, answer, locked}, {t.led, t.ans, t.lock});
        end
      end
    end
  end

  initial begin : answer_monitor
    logic [2:0] prev_ans;
    logic       prev_lock;
    evt_t       e;
    prev_ans  = 3'b000;
    prev_lock = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && (answer !== prev_ans || locked !== prev_lock)) begin
        if (evt_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL answer_event unexpected at cycle %0d: got %b_%b, want no change",
                   cyc, answer, locked);
        end else begin
          e = evt_q.pop_front();
          checkOutput("answer_event", {4'b0000, answer, locked}, {4'b0000, e.ans, e.lock});
        end
      end
      prev_ans  = answer;
      prev_lock = locked;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int k;

    repeat (3) applyStimulus(4'h0, 1'b0, 1'b0, 1'b1);
    expect_at(cyc + 1, "in_reset");
    mon_en = 1'b1;
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    expect_at(cyc + 1, "after_reset");

    $display("[TB] correct code 1,2,3,4");
    enter_code(16'h1234, "pass1");
    finish_show("pass1");

    $display("[TB] i_Enter held for 20 cycles");
    applyStimulus(4'h1, 1'b1, 1'b0, 1'b0);
    k = cyc + 1;
    m_led = 4'b0001;
    expect_at(k, "hold_first");
    repeat (19) applyStimulus(4'h1, 1'b1, 1'b0, 1'b0);
    expect_at(cyc + 1, "hold_single");
    applyStimulus(4'h0, 1'b0, 1'b1, 1'b0);
    m_led = 4'b0000;
    expect_at(cyc + 1, "hold_cleared");
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] clear together with a commit");
    applyStimulus(4'h1, 1'b1, 1'b0, 1'b0);
    m_led = 4'b0001;
    expect_at(cyc + 1, "clr_digit0");
    applyStimulus(4'h1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h2, 1'b1, 1'b0, 1'b0);
    m_led = 4'b0011;
    expect_at(cyc + 1, "clr_digit1");
    applyStimulus(4'h2, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h3, 1'b1, 1'b1, 1'b0);
    m_led = 4'b0000;
    expect_at(cyc + 1, "clear_wins");
    applyStimulus(4'h3, 1'b0, 1'b0, 1'b0);
    enter_code(16'h1234, "pass2");
    finish_show("pass2");

    $display("[TB] three wrong codes then lockout");
    enter_code(16'h1235, "fail1");
    finish_show("fail1");
    enter_code(16'h1235, "fail2");
    finish_show("fail2");
    enter_code(16'h1235, "fail3");
    finish_lockout("lock");

    $display("[TB] reset during SHOW");
    enter_code(16'h1234, "pre_reset");
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b1);
    m_led   = 4'b0000;
    m_ans   = 3'b000;
    m_lock  = 1'b0;
    m_fails = 0;
    note_answer();
    expect_at(cyc + 1, "reset_in_show");
    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0);
    enter_code(16'h1234, "post_reset");
    finish_show("post_reset");

`ifdef CODE_CHANGE_EN
    $display("[TB] reprogram code to 9,9,9,9");
    change = 1'b1;
    enter_code(16'h1234, "prog_pass");
    finish_show("prog_pass");
    change = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h9, 1'b1, 1'b0, 1'b0);
      if (i < 3) m_led[i] = 1'b1;
      else       m_led = 4'b0000;
      expect_at(cyc + 1, $sformatf("prog_digit%0d", i));
      applyStimulus(4'h9, 1'b0, 1'b0, 1'b0);
    end
    m_code = 16'h9999;
    enter_code(16'h1234, "old_code");
    finish_show("old_code");
    enter_code(16'h9999, "new_code");
    finish_show("new_code");
`endif

    repeat (3) @(negedge clk);
    vectors++;
    if (timed_q.size() + evt_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL queues_drained: %0d timed and %0d answer entries left, want 0",
               timed_q.size(), evt_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/passcode_lock_n.md
PASSCODE_LOCK_N -- requirements
Module: passcode_lock_n

Interface
REQ-001 Parameter DIGITS, default 4: number of code digits, range 1..8.
REQ-002 Parameter DIGIT_W, default 4: bits per digit, range 1..8.
REQ-003 Parameter DEFAULT_CODE, default 'h1234, width DIGITS*DIGIT_W: reset code; digit 0 occupies the MS nibble.
REQ-004 Parameter MAX_FAILS, default 3: consecutive failures that trigger lockout, range 1..15.
REQ-005 Parameter COUNT_TICK, default 12500000: clock cycles per blink half-period.
REQ-006 Parameter BLINK_TOGGLES, default 7: LED toggles in the result display.
REQ-007 Parameter LOCKOUT_TICKS, default 16: blink half-periods spent in lockout.
REQ-008 i_Clk  in  1  sole clock; all logic on its rising edge.
REQ-009 i_Rst  in  1  reset; synchronous, active-high.
REQ-010 i_Enter  in  1  digit-commit switch (level); edge-detected internally.
REQ-011 i_Clear  in  1  abort the current entry (level).
REQ-012 i_Digit  in  DIGIT_W  digit value, sampled on a commit.
REQ-013 o_Digit_LED  out  DIGITS  per-digit progress and blink LEDs.
REQ-014 o_Answer  out  3  000 idle, 001 pass, 010 fail, 100 locked out.
REQ-015 o_Locked  out  1  high while in LOCKOUT.

Function
REQ-016 A commit SHALL be i_Enter high while its one-cycle-delayed register is low; the digit is captured in that same cycle.
REQ-017 States SHALL be ENTRY, CHECK, SHOW and LOCKOUT.
REQ-018 ENTRY: the digit index starts at 0; each commit writes i_Digit into the slot at the index, sets o_Digit_LED[index] and increments the index.
REQ-019 ENTRY: the commit that fills slot DIGITS-1 SHALL move the FSM to CHECK on the next edge.
REQ-020 ENTRY: i_Clear high SHALL zero the index and o_Digit_LED within 1 cycle and keep the state; i_Clear SHALL win over a simultaneous commit.
REQ-021 CHECK lasts 1 cycle.
REQ-022 CHECK on a match: o_Answer=001 and the fail counter clears.
REQ-023 CHECK on a mismatch: o_Answer=010 and the fail counter increments, saturating at MAX_FAILS.
REQ-024 CHECK exits to LOCKOUT when the fail counter reaches MAX_FAILS, otherwise to SHOW.
REQ-025 SHOW: all LEDs are set on entry, then every COUNT_TICK cycles they invert.
REQ-026 SHOW: after BLINK_TOGGLES toggles the FSM returns to ENTRY with LEDs cleared and the index at 0; o_Answer holds until the next CHECK.
REQ-027 LOCKOUT: o_Answer=100 and o_Locked=1; LEDs blink as in SHOW; commits are ignored.
REQ-028 LOCKOUT: after LOCKOUT_TICKS half-periods the fail counter clears, o_Answer=000 and the FSM enters ENTRY.
REQ-029 The tick counter SHALL be sized $clog2(COUNT_TICK+1) bits, zeroed on every state change, and never wrap past COUNT_TICK.
REQ-030 Commits and i_Clear SHALL be ignored outside ENTRY, except as stated in REQ-035.

Reset
REQ-031 i_Rst SHALL put the FSM in ENTRY and zero the index, fail counter, tick counter, o_Digit_LED, o_Answer and o_Locked.
REQ-032 i_Rst SHALL load the stored code from DEFAULT_CODE and zero the entry buffer.
REQ-033 i_Rst SHALL zero the edge register, so an i_Enter held through reset is not a commit.
REQ-034 Reset mid-operation, in any state, SHALL take effect on the next edge.

Configuration
REQ-035 Macro CODE_CHANGE_EN SHALL add input i_Change (1 bit) and state PROGRAM.
REQ-036 With CODE_CHANGE_EN: i_Change high during a SHOW entered on a match SHALL go to PROGRAM instead of ENTRY.
REQ-037 PROGRAM SHALL collect DIGITS commits as in ENTRY, then write them to the stored code and set o_Answer=001.
REQ-038 PROGRAM: i_Clear SHALL abort to ENTRY leaving the code unchanged.
REQ-039 Without CODE_CHANGE_EN the code is constant DEFAULT_CODE, and neither i_Change nor PROGRAM exists.

Structure
REQ-040 Package passcode_lock_pkg SHALL hold the state enum and the o_Answer encodings ANS_IDLE, ANS_PASS, ANS_FAIL and ANS_LOCK.
REQ-041 Sub-module edge_detect_rise (1-bit, sync reset) SHALL provide the commit strobe.

Verification (COUNT_TICK=4, defaults otherwise)
REQ-042 Commit digits 1,2,3,4 -> o_Digit_LED steps 0001->0011->0111->1111; o_Answer=001 two cycles after the 4th commit.
REQ-043 Commit 1,2,3,5 three times -> o_Answer=010, 010, then 100; o_Locked=1; 16*4 cycles later o_Locked=0 and o_Answer=000.
REQ-044 Commit 1,2, then i_Clear together with a 3rd commit -> o_Digit_LED=0000; then 1,2,3,4 -> pass.
REQ-045 Hold i_Enter high for 20 cycles -> exactly 1 digit captured.
REQ-046 Assert i_Rst during SHOW -> all outputs 0 on the next cycle; 1,2,3,4 -> pass.
REQ-047 With CODE_CHANGE_EN: pass with i_Change=1, enter 9,9,9,9 -> 1,2,3,4 now fails and 9,9,9,9 passes.
